// File: rtl/hazard_stall_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_stall_scheduler
//  Purpose  : Pipeline sequencing controller for the 5-stage RV32 core.
//             Resolves cache misses, branch/JALR redirects, load-use hazards
//             and JAL redirects into per-stage stall/flush controls. Selects
//             EX operand forwarding sources, counts fetch-stall cycles and
//             flags over-long cache-miss episodes.
//  Ports    : CPU_CLK, CPU_RST_N        clock, async active-low reset
//             ICacheMiss, DCacheMiss    cache-not-ready levels
//             BranchE, JalrE, JalD      control-flow events
//             Rs1D/Rs2D, Rs1E/Rs2E      source registers in ID / EX
//             RegReadE                  [1]=Rs1E used, [0]=Rs2E used
//             MemToRegE, RdE/RdM/RdW    load flag and destination registers
//             RegWriteM, RegWriteW      write mode, nonzero means writes
//             Stall*/Flush*             per-stage hold / bubble controls
//             Forward1E, Forward2E      00=regfile 10=ResultM 01=W write data
//             StallCycles               saturating count of StallF cycles
//             MissTimeout               sticky over-long miss flag
//  Revision : 1.0  initial release
// ============================================================================
module hazard_stall_scheduler #(
    parameter int MISS_TIMEOUT = 255,
    parameter int CNT_W        = 32
) (
    input  logic             CPU_CLK,
    input  logic             CPU_RST_N,
    input  logic             ICacheMiss,
    input  logic             DCacheMiss,
    input  logic             BranchE,
    input  logic             JalrE,
    input  logic             JalD,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [1:0]       RegReadE,
    input  logic             MemToRegE,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [2:0]       RegWriteM,
    input  logic [2:0]       RegWriteW,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushF,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic [1:0]       Forward1E,
    output logic [1:0]       Forward2E,
    output logic [CNT_W-1:0] StallCycles,
    output logic             MissTimeout
);

    localparam logic [1:0]       c_st_run   = 2'd0;
    localparam logic [1:0]       c_st_imiss = 2'd1;
    localparam logic [1:0]       c_st_dmiss = 2'd2;
    localparam logic [15:0]      c_timeout  = 16'(MISS_TIMEOUT);
    localparam logic [15:0]      c_tmr_max  = 16'hFFFF;
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_redir_pend;
    logic             w_redir_set;
    logic             w_redir_clr;
    logic [15:0]      r_timer;
    logic [15:0]      w_timer_nxt;
    logic             r_miss_timeout;
    logic [CNT_W-1:0] r_stall_cycles;
    logic             w_redirect;
    logic             w_load_use;

    assign w_redirect = BranchE | JalrE;
    assign w_load_use = MemToRegE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_run: begin
                if (DCacheMiss)      w_state_nxt = c_st_dmiss;
                else if (ICacheMiss) w_state_nxt = c_st_imiss;
            end
            c_st_imiss: begin
                if (DCacheMiss)      w_state_nxt = c_st_dmiss;
                else if (!ICacheMiss) w_state_nxt = c_st_run;
            end
            c_st_dmiss: begin
                if (!DCacheMiss) w_state_nxt = ICacheMiss ? c_st_imiss : c_st_run;
            end
            default: w_state_nxt = c_st_run;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: stall/flush priority chain and forwarding selects.
    // Everything here is zero-latency from the current inputs; reset
    // forces the pipeline to bubbles with no stalls.
    // ------------------------------------------------------------------
    always_comb begin
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        StallM      = 1'b0;
        StallW      = 1'b0;
        FlushF      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushM      = 1'b0;
        FlushW      = 1'b0;
        Forward1E   = 2'b00;
        Forward2E   = 2'b00;
        w_redir_set = 1'b0;
        w_redir_clr = 1'b0;

        if (!CPU_RST_N) begin
            FlushF = 1'b1;
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
            FlushW = 1'b1;
        end else begin
            if (DCacheMiss) begin
                // Freeze F..M; a branch sitting in EX stays there and is
                // acted on once the data side is ready again.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (ICacheMiss) begin
                StallF = 1'b1;
                FlushD = 1'b1;
                if (w_redirect) begin
                    // The redirect target fetch is still outstanding behind
                    // the miss; remember to drop what the miss returns.
                    FlushE      = 1'b1;
                    w_redir_set = 1'b1;
                end
            end else begin
                if (w_redirect) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (w_load_use) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end else if (JalD) begin
                    FlushD = 1'b1;
                end
                // First cycle after the I-miss: the returned fetch is wrong-path.
                if (r_redir_pend) begin
                    FlushD      = 1'b1;
                    w_redir_clr = 1'b1;
                end
            end

            // Operand 1: M stage has priority over W stage.
            if (RegReadE[1] && (RegWriteM != 3'b000) && (RdM != 5'd0) && (RdM == Rs1E)) begin
                Forward1E = 2'b10;
            end else if (RegReadE[1] && (RegWriteW != 3'b000) && (RdW != 5'd0) && (RdW == Rs1E)) begin
                Forward1E = 2'b01;
            end

            // Operand 2: same rules on Rs2E / RegReadE[0].
            if (RegReadE[0] && (RegWriteM != 3'b000) && (RdM != 5'd0) && (RdM == Rs2E)) begin
                Forward2E = 2'b10;
            end else if (RegReadE[0] && (RegWriteW != 3'b000) && (RdW != 5'd0) && (RdW == Rs2E)) begin
                Forward2E = 2'b01;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending-redirect flag
    // ------------------------------------------------------------------
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            r_redir_pend <= 1'b0;
        end else if (w_redir_set) begin
            r_redir_pend <= 1'b1;
        end else if (w_redir_clr) begin
            r_redir_pend <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Miss timer and sticky timeout. The timer counts every cycle that
    // leads into (or stays in) a miss state, so it equals the number of
    // miss cycles seen so far in the current episode.
    // ------------------------------------------------------------------
    always_comb begin
        if (w_state_nxt == c_st_run) begin
            w_timer_nxt = 16'd0;
        end else if (r_timer == c_tmr_max) begin
            w_timer_nxt = r_timer;
        end else begin
            w_timer_nxt = r_timer + 16'd1;
        end
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            r_timer        <= 16'd0;
            r_miss_timeout <= 1'b0;
        end else begin
            r_timer <= w_timer_nxt;
            if (w_timer_nxt == c_timeout) begin
                r_miss_timeout <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating fetch-stall counter
    // ------------------------------------------------------------------
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            r_stall_cycles <= '0;
        end else if (StallF && (r_stall_cycles != c_cnt_max)) begin
            r_stall_cycles <= r_stall_cycles + c_cnt_one;
        end
    end

    assign StallCycles = r_stall_cycles;
    assign MissTimeout = r_miss_timeout;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_stall_scheduler
//  Purpose  : Self-checking bench for hazard_stall_scheduler. Each scenario
//             pushes the expected stall/flush/forward vector when it drives a
//             cycle and pops it when the outputs are sampled mid-cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_stall_scheduler;

    localparam int c_miss_timeout = 4;
    localparam int c_cnt_w        = 4;

    logic               CPU_CLK   = 1'b0;
    logic               CPU_RST_N = 1'b1;
    logic               ICacheMiss, DCacheMiss, BranchE, JalrE, JalD;
    logic [4:0]         Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]         RegReadE;
    logic               MemToRegE;
    logic [2:0]         RegWriteM, RegWriteW;
    logic               StallF, StallD, StallE, StallM, StallW;
    logic               FlushF, FlushD, FlushE, FlushM, FlushW;
    logic [1:0]         Forward1E, Forward2E;
    logic [c_cnt_w-1:0] StallCycles;
    logic               MissTimeout;

    hazard_stall_scheduler #(
        .MISS_TIMEOUT (c_miss_timeout),
        .CNT_W        (c_cnt_w)
    ) dut (
        .CPU_CLK     (CPU_CLK),
        .CPU_RST_N   (CPU_RST_N),
        .ICacheMiss  (ICacheMiss),
        .DCacheMiss  (DCacheMiss),
        .BranchE     (BranchE),
        .JalrE       (JalrE),
        .JalD        (JalD),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RegReadE    (RegReadE),
        .MemToRegE   (MemToRegE),
        .RdE         (RdE),
        .RdM         (RdM),
        .RdW         (RdW),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .StallW      (StallW),
        .FlushF      (FlushF),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushM      (FlushM),
        .FlushW      (FlushW),
        .Forward1E   (Forward1E),
        .Forward2E   (Forward2E),
        .StallCycles (StallCycles),
        .MissTimeout (MissTimeout)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    // stall/flush bit order: {F, D, E, M, W}
    typedef struct packed {
        logic [4:0] stall;
        logic [4:0] flush;
        logic [1:0] f1;
        logic [1:0] f2;
    } vec_t;

    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [4:0] s, input logic [4:0] f,
                                input logic [1:0] a, input logic [1:0] b);
        vec_t v;
        v.stall = s;
        v.flush = f;
        v.f1    = a;
        v.f2    = b;
        return v;
    endfunction

    function automatic vec_t observe();
        vec_t v;
        v.stall = {StallF, StallD, StallE, StallM, StallW};
        v.flush = {FlushF, FlushD, FlushE, FlushM, FlushW};
        v.f1    = Forward1E;
        v.f2    = Forward2E;
        return v;
    endfunction

    task automatic idle_inputs();
        ICacheMiss = 1'b0; DCacheMiss = 1'b0; BranchE = 1'b0; JalrE = 1'b0; JalD = 1'b0;
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0; RegReadE = 2'b00; MemToRegE = 1'b0;
        RegWriteM = 3'b000; RegWriteW = 3'b000;
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic pulse_reset();
        #1 CPU_RST_N = 1'b0;
        next_cycle();
        CPU_RST_N = 1'b1;
    endtask

    task automatic test_reset();
        vec_t e, o;
        idle_inputs();
        // Hostile inputs: reset must dominate every one of them.
        DCacheMiss = 1'b1; ICacheMiss = 1'b1; BranchE = 1'b1;
        MemToRegE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
        RdM = 5'd3; RegWriteM = 3'b001; Rs1E = 5'd3; RegReadE = 2'b11;
        #1 CPU_RST_N = 1'b0;
        sb.push_back(mk(5'b00000, 5'b11111, 2'b00, 2'b00));
        #1;
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL reset_outputs: got %h want %h", o, e);
        end
        checks++;
        if (StallCycles !== 4'd0 || MissTimeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: got cnt=%0d to=%b want cnt=0 to=0", StallCycles, MissTimeout);
        end
        next_cycle();
        idle_inputs();
        CPU_RST_N = 1'b1;
        sb.push_back(mk(5'b00000, 5'b00000, 2'b00, 2'b00));
        #3;
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL reset_release_idle: got %h want %h", o, e);
        end
    endtask

    task automatic test_load_use();
        vec_t e, o;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            idle_inputs();
            case (i)
                0: begin // lw x5 in EX, add x6,x5,x1 in ID
                    MemToRegE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; Rs2D = 5'd1;
                    sb.push_back(mk(5'b11000, 5'b00100, 2'b00, 2'b00));
                end
                1: begin // bubble in EX, load in M
                    RdM = 5'd5; RegWriteM = 3'b001; Rs1D = 5'd5; Rs2D = 5'd1;
                    sb.push_back(mk(5'b00000, 5'b00000, 2'b00, 2'b00));
                end
                2: begin // add in EX, load in W
                    Rs1E = 5'd5; Rs2E = 5'd1; RegReadE = 2'b11; RdW = 5'd5; RegWriteW = 3'b001;
                    sb.push_back(mk(5'b00000, 5'b00000, 2'b01, 2'b00));
                end
                3: begin // hazard on Rs2
                    MemToRegE = 1'b1; RdE = 5'd7; Rs1D = 5'd2; Rs2D = 5'd7;
                    sb.push_back(mk(5'b11000, 5'b00100, 2'b00, 2'b00));
                end
                4: begin // load to x0 never stalls
                    MemToRegE = 1'b1; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
                    sb.push_back(mk(5'b00000, 5'b00000, 2'b00, 2'b00));
                end
                default: begin // non-load producer: forwarding covers it
                    RdE = 5'd5; Rs1D = 5'd5;
                    sb.push_back(mk(5'b00000, 5'b00000, 2'b00, 2'b00));
                end
            endcase
            #3;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL load_use cyc%0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_forward();
        vec_t e, o;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            idle_inputs();
            case (i)
                0: begin // addi x3 in M, sub x4,x3,x3 in EX
                    RdM = 5'd3; RegWriteM = 3'b001; Rs1E = 5'd3; Rs2E = 5'd3; RegReadE = 2'b11;
                    sb.push_back(mk(5'b00000, 5'b00000, 2'b10, 2'b10));
                end
                1: begin // rd = x0 in both stages
                    RegWriteM = 3'b001; RegWriteW = 3'b001; RegReadE = 2'b11;
                    sb.push_back(mk(5'b00000, 5'b00000, 2'b00, 2'b00));
                end
                2: begin // M beats W; operand 2 unused
                    RdM = 5'd9; RdW = 5'd9; RegWriteM = 3'b010; RegWriteW = 3'b001;
                    Rs1E = 5'd9; Rs2E = 5'd9; RegReadE = 2'b10;
                    sb.push_back(mk(5'b00000, 5'b00000, 2'b10, 2'b00));
                end
                3: begin // M not writing, W supplies both
                    RdM = 5'd9; RdW = 5'd9; RegWriteW = 3'b100;
                    Rs1E = 5'd9; Rs2E = 5'd9; RegReadE = 2'b11;
                    sb.push_back(mk(5'b00000, 5'b00000, 2'b01, 2'b01));
                end
                default: begin // operand 1 unused, mixed sources for operand 2
                    RdM = 5'd12; RegWriteM = 3'b001; RdW = 5'd13; RegWriteW = 3'b001;
                    Rs1E = 5'd12; Rs2E = 5'd13; RegReadE = 2'b01;
                    sb.push_back(mk(5'b00000, 5'b00000, 2'b00, 2'b01));
                end
            endcase
            #3;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL forward cyc%0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_dmiss_branch();
        vec_t e, o;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            idle_inputs();
            if (i < 3) begin
                DCacheMiss = 1'b1; BranchE = 1'b1;
                sb.push_back(mk(5'b11110, 5'b00001, 2'b00, 2'b00));
            end else if (i == 3) begin
                BranchE = 1'b1;
                sb.push_back(mk(5'b00000, 5'b01100, 2'b00, 2'b00));
            end else begin
                sb.push_back(mk(5'b00000, 5'b00000, 2'b00, 2'b00));
            end
            #3;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL dmiss_branch cyc%0d: got %h want %h", i, o, e);
            end
        end
        // Three miss cycles stays below the limit of four.
        checks++;
        if (MissTimeout !== 1'b0) begin
            errors++;
            $display("FAIL dmiss_no_timeout: got %b want 0", MissTimeout);
        end
    endtask

    task automatic test_imiss_redirect();
        vec_t e, o;
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            idle_inputs();
            case (i)
                0, 2, 3: begin
                    ICacheMiss = 1'b1;
                    sb.push_back(mk(5'b10000, 5'b01000, 2'b00, 2'b00));
                end
                1: begin
                    ICacheMiss = 1'b1; BranchE = 1'b1;
                    sb.push_back(mk(5'b10000, 5'b01100, 2'b00, 2'b00));
                end
                4, 7: begin // miss falls: wrong-path fetch dropped
                    sb.push_back(mk(5'b00000, 5'b01000, 2'b00, 2'b00));
                end
                6: begin
                    ICacheMiss = 1'b1; JalrE = 1'b1;
                    sb.push_back(mk(5'b10000, 5'b01100, 2'b00, 2'b00));
                end
                default: begin // pending redirect already consumed
                    sb.push_back(mk(5'b00000, 5'b00000, 2'b00, 2'b00));
                end
            endcase
            #3;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL imiss_redirect cyc%0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_priority();
        vec_t e, o;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            idle_inputs();
            case (i)
                0: begin // JAL alone
                    JalD = 1'b1;
                    sb.push_back(mk(5'b00000, 5'b01000, 2'b00, 2'b00));
                end
                1: begin // branch beats load-use
                    BranchE = 1'b1; MemToRegE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
                    sb.push_back(mk(5'b00000, 5'b01100, 2'b00, 2'b00));
                end
                2: begin // load-use beats JAL
                    JalD = 1'b1; MemToRegE = 1'b1; RdE = 5'd5; Rs2D = 5'd5;
                    sb.push_back(mk(5'b11000, 5'b00100, 2'b00, 2'b00));
                end
                3: begin // I-miss beats load-use
                    ICacheMiss = 1'b1; MemToRegE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
                    sb.push_back(mk(5'b10000, 5'b01000, 2'b00, 2'b00));
                end
                default: begin // D-miss beats everything, forwarding still live
                    DCacheMiss = 1'b1; ICacheMiss = 1'b1; JalD = 1'b1; JalrE = 1'b1;
                    RdM = 5'd4; RegWriteM = 3'b001; Rs1E = 5'd4; RegReadE = 2'b10;
                    sb.push_back(mk(5'b11110, 5'b00001, 2'b10, 2'b00));
                end
            endcase
            #3;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL priority cyc%0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_timeout();
        vec_t e, o;
        logic [3:0] exp_cnt;
        logic       exp_to;
        idle_inputs();
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            idle_inputs();
            if (i < 6) begin
                ICacheMiss = 1'b1;
                sb.push_back(mk(5'b10000, 5'b01000, 2'b00, 2'b00));
            end else begin
                sb.push_back(mk(5'b00000, 5'b00000, 2'b00, 2'b00));
            end
            #3;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL timeout_ctl cyc%0d: got %h want %h", i, o, e);
            end
            // Flag visible from the 5th miss cycle (i=4) onward, sticky after.
            exp_to  = (i >= 4);
            exp_cnt = (i < 6) ? 4'(i) : 4'd6;
            checks++;
            if (MissTimeout !== exp_to || StallCycles !== exp_cnt) begin
                errors++;
                $display("FAIL timeout_regs cyc%0d: got to=%b cnt=%0d want to=%b cnt=%0d",
                         i, MissTimeout, StallCycles, exp_to, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_miss();
        vec_t e, o;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            idle_inputs();
            DCacheMiss = 1'b1;
            sb.push_back(mk(5'b11110, 5'b00001, 2'b00, 2'b00));
            #3;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL midmiss_ctl cyc%0d: got %h want %h", i, o, e);
            end
        end
        // Assert reset between clock edges with the miss still high.
        #1 CPU_RST_N = 1'b0;
        sb.push_back(mk(5'b00000, 5'b11111, 2'b00, 2'b00));
        #1;
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL midmiss_async_reset: got %h want %h", o, e);
        end
        checks++;
        if (StallCycles !== 4'd0 || MissTimeout !== 1'b0) begin
            errors++;
            $display("FAIL midmiss_async_regs: got cnt=%0d to=%b want cnt=0 to=0", StallCycles, MissTimeout);
        end
        next_cycle();
        idle_inputs();
        CPU_RST_N = 1'b1;
        next_cycle();
        sb.push_back(mk(5'b00000, 5'b00000, 2'b00, 2'b00));
        #3;
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e || StallCycles !== 4'd0) begin
            errors++;
            $display("FAIL midmiss_after_release: got %h cnt=%0d want %h cnt=0", o, StallCycles, e);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_cnt;
        for (int i = 0; i < 19; i++) begin
            next_cycle();
            idle_inputs();
            ICacheMiss = (i < 18);
            #3;
            exp_cnt = (i < 15) ? 4'(i) : 4'd15;
            checks++;
            if (StallCycles !== exp_cnt) begin
                errors++;
                $display("FAIL stall_saturate cyc%0d: got %0d want %0d", i, StallCycles, exp_cnt);
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_use();
        test_forward();
        test_dmiss_branch();
        test_imiss_redirect();
        test_priority();
        test_timeout();
        test_reset_mid_miss();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
